instruction_fetch_unit: RTL
===========================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
 instructionWidth, 32, instruction word bits
 addressSize, 64, address bits
 queueDepth, 4, instruction queue entries (power of 2)
 resetVector, 0, PC after reset
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
 clock_i  in  1  single clock; all state updates on its rising edge
 reset_i  in  1  synchronous active-low reset
 stall_i  in  1  downstream format-class decoder cannot accept this cycle
 redirect_i  in  1  branch/flush request
 redirectAddress_i  in  addressSize  new fetch PC
 memReq_o  out  1  memory read request
 memAddress_o  out  addressSize  request address
 memReady_i  in  1  memory accepts request this cycle
 memValid_i  in  1  response data valid
 memData_i  in  instructionWidth  response instruction word
 instruction_o  out  instructionWidth  instruction to decoder instruction_i
 address_o  out  addressSize  instruction address to decoder address_i
 enable_o  out  1  one-cycle valid to decoder enable_i
REQ-003 Bit 0 SHALL be the MSB of every vector.

Function
REQ-004 FSM states SHALL be IDLE, REQ, WAIT, DISCARD.
REQ-005 IDLE->REQ when queue occupancy < queueDepth; memReq_o=1 and memAddress_o=PC in REQ only.
REQ-006 REQ->WAIT on memReady_i=1; memReq_o and memAddress_o SHALL hold stable until accepted.
REQ-007 WAIT->IDLE on memValid_i=1: push {memData_i, PC} into queue, PC <= PC+4 (wraps modulo 2^addressSize).
REQ-008 At most one request SHALL be outstanding; a queue slot SHALL be free for it before REQ is entered.
REQ-009 memValid_i outside WAIT/DISCARD SHALL be ignored.
REQ-010 Pop: when stall_i=0 and queue non-empty, register head into instruction_o/address_o and set enable_o=1 next cycle; otherwise enable_o=0 and instruction_o/address_o hold.
REQ-011 Push and pop in the same cycle SHALL both occur; occupancy unchanged.
REQ-012 Latency: memValid_i in cycle N with empty queue and stall_i=0 -> enable_o=1 in cycle N+2.
REQ-013 Instructions SHALL leave in fetch order, never duplicated or dropped except by redirect.
REQ-014 redirect_i=1: PC <= redirectAddress_i with bits [addressSize-2:addressSize-1] forced to 0, queue emptied, no pop (enable_o=0 next cycle).
REQ-015 Redirect in REQ (not yet accepted) -> IDLE; in REQ with memReady_i=1 same cycle -> DISCARD; in WAIT -> DISCARD; in DISCARD -> stay DISCARD.
REQ-016 DISCARD->IDLE on memValid_i=1, data dropped, PC unchanged.
REQ-017 Redirect coincident with memValid_i in WAIT SHALL drop that response and go to IDLE.
REQ-018 Redirect SHALL take priority over push, pop and PC increment.

Reset
REQ-019 reset_i=0 at a rising edge SHALL set PC=resetVector, state IDLE, queue empty, memReq_o=0, memAddress_o=0, enable_o=0, instruction_o=0, address_o=0, regardless of redirect_i or memory inputs.
REQ-020 A response arriving in the cycle after reset release SHALL be ignored (state IDLE).

Verification
REQ-021 Reset release, memReady_i=1, memory returns word at address A one cycle after acceptance, stall_i=0 -> enable_o pulses with address_o=0,4,8,12 and matching instruction_o.
REQ-022 stall_i=1 held for 20 cycles -> exactly 4 requests issued, memReq_o then stays 0; release stall -> 4 in-order enable_o pulses, then fetching resumes at 16.
REQ-023 redirect_i=1, redirectAddress_i=0x1003 while in WAIT -> next response discarded, next request address 0x1000, no stale instruction emitted.
REQ-024 memReady_i=0 for 5 cycles -> memReq_o and memAddress_o stable all 5 cycles.
REQ-025 PC=0xFFFF_FFFF_FFFF_FFFC fetched -> address_o of that word 0xFFFF_FFFF_FFFF_FFFC, next request address 0.
REQ-026 reset_i=0 asserted in WAIT with queue holding 2 entries -> enable_o=0 and memReq_o=0 next cycle, following request address = resetVector.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if
//   Bundles the fetch unit's memory read port and its decoder-facing output.
//   Vectors use bit 0 as the MSB.
//   master : the fetch unit (drives memReq_o/memAddress_o and the decoder outputs)
//   slave  : memory + decoder side (drives ready/valid/data and stall)
//   Signals:
//     memReq_o, memAddress_o       read request and its address
//     memReady_i                   memory accepts the request this cycle
//     memValid_i, memData_i        read response
//     stall_i                      decoder cannot accept this cycle
//     instruction_o, address_o     instruction word and its address to the decoder
//     enable_o                     one-cycle valid for instruction_o/address_o
interface instruction_fetch_unit_if #(
  parameter int instructionWidth = 32,
  parameter int addressSize      = 64
);
  logic                          memReq_o;
  logic [0:addressSize-1]        memAddress_o;
  logic                          memReady_i;
  logic                          memValid_i;
  logic [0:instructionWidth-1]   memData_i;
  logic                          stall_i;
  logic [0:instructionWidth-1]   instruction_o;
  logic [0:addressSize-1]        address_o;
  logic                          enable_o;

  modport master (
    output memReq_o, memAddress_o, instruction_o, address_o, enable_o,
    input  memReady_i, memValid_i, memData_i, stall_i
  );

  modport slave (
    input  memReq_o, memAddress_o, instruction_o, address_o, enable_o,
    output memReady_i, memValid_i, memData_i, stall_i
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Fetches sequential instruction words from memory (one outstanding read at
//   a time), buffers them with their addresses in a small FIFO and hands them
//   to the decoder one per cycle when it is not stalled. A redirect flushes the
//   FIFO, restarts fetching at a word-aligned new PC and drops any in-flight
//   response. Vectors use bit 0 as the MSB.
//   Ports:
//     clock_i            clock, rising edge
//     reset_i            synchronous active-low reset
//     redirect_i         branch/flush request
//     redirectAddress_i  new fetch PC (low two bits ignored)
//     bus                memory request/response and decoder output (master)
//   queueDepth must be a power of two, at least 2.
module instruction_fetch_unit #(
  parameter int                     instructionWidth = 32,
  parameter int                     addressSize      = 64,
  parameter int                     queueDepth       = 4,
  parameter logic [0:addressSize-1] resetVector      = '0
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   redirect_i,
  input  logic [0:addressSize-1] redirectAddress_i,
  instruction_fetch_unit_if.master bus
);

  localparam int PTR_W = $clog2(queueDepth);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(queueDepth);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;

  state_t                      state_q, state_d;
  logic [0:addressSize-1]      pc_q;
  logic [0:addressSize-1]      redirect_pc;
  logic [0:instructionWidth-1] q_instr [queueDepth];
  logic [0:addressSize-1]      q_addr  [queueDepth];
  logic [PTR_W-1:0]            rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]            count_q;
  logic                        push, pop;

  // Redirect targets are forced word-aligned (bit 0 is the MSB, so the two
  // least significant bits are the highest indices).
  always_comb begin
    redirect_pc = redirectAddress_i;
    redirect_pc[addressSize-2:addressSize-1] = 2'b00;
  end

  // A request is only started when a FIFO slot is free; nothing else pushes,
  // so that slot stays reserved until the response lands.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q < DEPTH) state_d = REQ;
      end
      REQ: begin
        if (redirect_i)            state_d = bus.memReady_i ? DISCARD : IDLE;
        else if (bus.memReady_i)   state_d = WAIT;
      end
      WAIT: begin
        // A response coinciding with a redirect is the stale one: drop it.
        if (bus.memValid_i) begin
          state_d = IDLE;
          push    = !redirect_i;
        end else if (redirect_i) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        // The response still owed to memory ends the discard, even when a
        // further redirect arrives in the same cycle.
        if (bus.memValid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop = !bus.stall_i && (count_q != '0) && !redirect_i;

  assign bus.memReq_o     = (state_q == REQ);
  assign bus.memAddress_o = (state_q == REQ) ? pc_q : '0;

  // Control, PC and decoder output registers
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q           <= IDLE;
      pc_q              <= resetVector;
      rd_ptr_q          <= '0;
      wr_ptr_q          <= '0;
      count_q           <= '0;
      bus.enable_o      <= 1'b0;
      bus.instruction_o <= '0;
      bus.address_o     <= '0;
    end else begin
      state_q <= state_d;
      if (redirect_i) begin
        pc_q     <= redirect_pc;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PTR_W'(1);
          pc_q     <= pc_q + addressSize'(4);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
      end
      bus.enable_o <= pop;
      if (pop) begin
        bus.instruction_o <= q_instr[rd_ptr_q];
        bus.address_o     <= q_addr[rd_ptr_q];
      end
    end
  end

  // FIFO storage; contents are only meaningful below count_q
  always_ff @(posedge clock_i) begin
    if (push) begin
      q_instr[wr_ptr_q] <= bus.memData_i;
      q_addr[wr_ptr_q]  <= pc_q;
    end
  end

endmodule
